// File: rtl/gray_pkg.sv
// Shared helpers for the Gray up/down counter: limit value and binary/Gray conversions.
// Functions work on a 32-bit container; callers zero-extend and truncate to their width.
package gray_pkg;

    localparam int unsigned MAX_WIDTH = 32;

    // All-ones value for a counter of the given width.
    function automatic logic [MAX_WIDTH-1:0] gray_max(input int unsigned width);
        return MAX_WIDTH'((64'(1) << width) - 64'(1));
    endfunction

    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
        logic [MAX_WIDTH-1:0] b;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_bin_n.sv
// Combinational Gray-to-binary converter: XOR chain running from the MSB down.
module gray_to_bin_n #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    assign bin[WIDTH-1] = gray[WIDTH-1];

    for (genvar i = int'(WIDTH) - 2; i >= 0; i--) begin : g_chain
        assign bin[i] = bin[i+1] ^ gray[i];
    end

endmodule

// File: rtl/gray_updown_counter.sv
// Up/down counter held in binary, published as registered binary and Gray code,
// with binary or Gray parallel load and optional saturation at the ends.
module gray_updown_counter
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned RESET_VALUE = 0,
    parameter bit          SATURATE    = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic             load_is_gray,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] MAX_BIN  = WIDTH'(gray_max(WIDTH));
    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(MAX_WIDTH'(RESET_VALUE)));

    logic [WIDTH-1:0] load_bin;
    logic [WIDTH:0]   inc_sum;
    logic [WIDTH:0]   dec_diff;
    logic [WIDTH-1:0] next_bin;
    logic             next_wrap;

    gray_to_bin_n #(.WIDTH(WIDTH)) u_g2b (
        .gray (load_val),
        .bin  (load_bin)
    );

    // Extra top bit carries the carry/borrow that flags a wrap step.
    assign inc_sum  = (WIDTH+1)'(bin_out) + (WIDTH+1)'(1);
    assign dec_diff = (WIDTH+1)'(bin_out) - (WIDTH+1)'(1);

    // Next-state mux: load > count > hold (reset handled in the register).
    always_comb begin
        next_bin  = bin_out;
        next_wrap = 1'b0;
        if (load) begin
            next_bin = load_is_gray ? load_bin : load_val;
        end else if (en) begin
            if (up) begin
                if (inc_sum[WIDTH] && SATURATE) begin
                    next_bin = bin_out;
                end else begin
                    next_bin  = inc_sum[WIDTH-1:0];
                    next_wrap = inc_sum[WIDTH];
                end
            end else begin
                if (dec_diff[WIDTH] && SATURATE) begin
                    next_bin = bin_out;
                end else begin
                    next_bin  = dec_diff[WIDTH-1:0];
                    next_wrap = dec_diff[WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_out  <= RST_BIN;
            gray_out <= RST_GRAY;
            wrap     <= 1'b0;
        end else begin
            bin_out  <= next_bin;
            gray_out <= WIDTH'(bin2gray(MAX_WIDTH'(next_bin)));
            wrap     <= next_wrap;
        end
    end

    assign at_limit = up ? (bin_out == MAX_BIN) : (bin_out == '0);

endmodule

// File: tb/tb_gray_updown_counter.sv
// Bench for gray_updown_counter: wrap and saturate instances driven in lockstep,
// directed scenarios followed by random stimulus, checked against an integer model.
module tb_gray_updown_counter;

    logic       clk = 1'b0;
    logic       rst_n, en, up, load, load_is_gray;
    logic [3:0] load_val;
    logic [3:0] bin_w, gray_w, bin_s, gray_s;
    logic       wrap_w, wrap_s, lim_w, lim_s;

    int n_cmp = 0;
    int n_err = 0;
    int m_bin [2];
    int m_wrap[2];
    logic [3:0] prev_gray[2];

    always #5 clk = ~clk;

    gray_updown_counter #(.WIDTH(4), .RESET_VALUE(5), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_is_gray(load_is_gray), .load_val(load_val),
        .bin_out(bin_w), .gray_out(gray_w), .wrap(wrap_w), .at_limit(lim_w)
    );

    gray_updown_counter #(.WIDTH(4), .RESET_VALUE(5), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_is_gray(load_is_gray), .load_val(load_val),
        .bin_out(bin_s), .gray_out(gray_s), .wrap(wrap_s), .at_limit(lim_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference decode: the binary value whose Gray code matches g.
    function automatic int gray_decode(input int g);
        for (int n = 0; n < 16; n++) begin
            if ((n ^ (n >> 1)) == g) return n;
        end
        return -1;
    endfunction

    function automatic void model_edge(input int i, input bit r, input bit e, input bit u,
                                       input bit l, input bit lg, input int lv);
        bit sat = (i == 1);
        m_wrap[i] = 0;
        if (!r) begin
            m_bin[i] = 5;
        end else if (l) begin
            m_bin[i] = lg ? gray_decode(lv) : lv;
        end else if (e) begin
            if (u) begin
                if (m_bin[i] == 15) begin
                    if (!sat) begin m_bin[i] = 0; m_wrap[i] = 1; end
                end else m_bin[i] = m_bin[i] + 1;
            end else begin
                if (m_bin[i] == 0) begin
                    if (!sat) begin m_bin[i] = 15; m_wrap[i] = 1; end
                end else m_bin[i] = m_bin[i] - 1;
            end
        end
    endfunction

    task automatic compare_all(input bit count_step, input int old_w, input int old_s);
        int lim_exp[2];
        for (int i = 0; i < 2; i++)
            lim_exp[i] = up ? int'(m_bin[i] == 15) : int'(m_bin[i] == 0);
        check("wrap.bin",  32'(bin_w),  32'(m_bin[0]));
        check("wrap.gray", 32'(gray_w), 32'(m_bin[0] ^ (m_bin[0] >> 1)));
        check("wrap.wrap", 32'(wrap_w), 32'(m_wrap[0]));
        check("wrap.lim",  32'(lim_w),  32'(lim_exp[0]));
        check("sat.bin",   32'(bin_s),  32'(m_bin[1]));
        check("sat.gray",  32'(gray_s), 32'(m_bin[1] ^ (m_bin[1] >> 1)));
        check("sat.wrap",  32'(wrap_s), 32'(m_wrap[1]));
        check("sat.lim",   32'(lim_s),  32'(lim_exp[1]));
        if (count_step && old_w != m_bin[0])
            check("wrap.gray_1bit", 32'($countones(prev_gray[0] ^ gray_w)), 32'd1);
        if (count_step && old_s != m_bin[1])
            check("sat.gray_1bit", 32'($countones(prev_gray[1] ^ gray_s)), 32'd1);
        prev_gray[0] = gray_w;
        prev_gray[1] = gray_s;
    endtask

    // Drive one cycle of inputs, advance the model on the edge, check 1 time unit later.
    task automatic cycle(input bit r, input bit e, input bit u, input bit l,
                         input bit lg, input int lv);
        int old_w = m_bin[0];
        int old_s = m_bin[1];
        rst_n = r; en = e; up = u; load = l; load_is_gray = lg; load_val = 4'(lv);
        @(posedge clk);
        model_edge(0, r, e, u, l, lg, lv);
        model_edge(1, r, e, u, l, lg, lv);
        #1;
        compare_all(r && !l && e, old_w, old_s);
    endtask

    initial begin
        m_bin[0] = 0; m_bin[1] = 0; m_wrap[0] = 0; m_wrap[1] = 0;
        prev_gray[0] = '0; prev_gray[1] = '0;

        // Reset held for two edges, with load and en asserted underneath.
        cycle(0, 1, 1, 1, 0, 9);
        cycle(0, 1, 1, 1, 0, 9);
        check("reset.bin_const",  32'(bin_w),  32'd5);
        check("reset.gray_const", 32'(gray_w), 32'd7);

        // Up sweep from 0 through the 1111 -> 0000 wrap.
        cycle(1, 0, 1, 1, 0, 0);
        for (int k = 0; k < 17; k++) cycle(1, 1, 1, 0, 0, 0);

        // Down wrap then direction flip back up.
        cycle(1, 0, 0, 1, 0, 1);
        cycle(1, 1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0);
        check("down_wrap.pulse", 32'(wrap_w), 32'd1);
        cycle(1, 1, 1, 0, 0, 0);
        check("flip_up.pulse", 32'(wrap_w), 32'd1);

        // Gray load with en also high: load wins.
        cycle(1, 1, 1, 1, 1, 11);
        check("gray_load.bin_const", 32'(bin_w), 32'd13);
        cycle(1, 0, 1, 0, 0, 0);

        // Saturation at the top.
        cycle(1, 0, 1, 1, 0, 14);
        for (int k = 0; k < 3; k++) cycle(1, 1, 1, 0, 0, 0);
        check("sat.hold_const", 32'(bin_s), 32'd15);

        // Reset mid-count overriding a load.
        cycle(1, 0, 1, 1, 0, 6);
        cycle(1, 1, 1, 0, 0, 0);
        cycle(0, 1, 1, 1, 1, 3);
        check("midreset.bin_const", 32'(bin_w), 32'd5);

        // Random stimulus; loads and resets are kept infrequent so counting dominates.
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(99) >= 3, $urandom_range(9) >= 2, 1'($urandom),
                  $urandom_range(9) == 0, 1'($urandom), int'($urandom_range(15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
